button_conditioner: RTL and testbench

- Input-side counterpart of the VGA and audio output path.
- Takes raw, bouncing, asynchronous push-button pins and synchronises and debounces them.
- Produces clean levels, one-cycle press pulses, and a per-frame snapshot of presses.
- The per-frame snapshot is handed to game logic on each frame-done tick, so no press between game updates is lost.

---
 rtl/breakout_input_pkg.sv | 25 ++
 rtl/button_debouncer.sv | 123 ++++++++++++
 rtl/button_conditioner.sv | 77 +++++++
 tb/tb_button_conditioner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/breakout_input_pkg.sv
// ============================================================================
// Module   : breakout_input_pkg
// Purpose  : Shared debounce-state encoding and button index constants.
// Options  : BUTTON_CONDITIONER_AUTOREPEAT_EN (used by button_debouncer)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package breakout_input_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } db_state_e;

  localparam int BTN_IDX_LEFT  = 0;
  localparam int BTN_IDX_RIGHT = 1;
  localparam int BTN_IDX_A     = 2;
  localparam int BTN_IDX_B     = 3;

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Purpose  : One button channel: 2-flop synchroniser, debounce FSM, press
//            pulse and, with BUTTON_CONDITIONER_AUTOREPEAT_EN, auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
  import breakout_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 400000
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 16000000,
  parameter int REPEAT_PERIOD = 4000000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]         sync_q;
  db_state_e          state_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               level_q;
  logic               press_q;
  logic               w_s;

  assign w_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      press_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (w_s) begin
            state_q <= PRESS_PENDING;
            cnt_q   <= '0;
          end
        end
        PRESS_PENDING: begin
          if (!w_s) begin
            state_q <= RELEASED;
          end else if (cnt_q == c_CNT_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            state_q <= RELEASE_PENDING;
            cnt_q   <= '0;
          end
        end
        RELEASE_PENDING: begin
          if (w_s) begin
            state_q <= PRESSED;
          end else if (cnt_q == c_CNT_LAST) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

  assign level_o = level_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int c_REP_W = $clog2(REPEAT_DELAY);
  localparam logic [c_REP_W-1:0] c_REP_LAST   = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_REP_RELOAD = c_REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [c_REP_W-1:0] rcnt_q;
  logic               rep_q;

  // The count keeps running through a pending release, but a repeat only
  // fires while the button is still seen held, so letting go stops repeats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (state_q == RELEASED || state_q == PRESS_PENDING) begin
        rcnt_q <= '0;
      end else if (state_q == PRESSED && w_s && rcnt_q == c_REP_LAST) begin
        rep_q  <= 1'b1;
        rcnt_q <= c_REP_RELOAD;
      end else if (rcnt_q != c_REP_LAST) begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q | rep_q;
`else
  assign press_o = press_q;
`endif

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : N debounced button channels plus a per-frame sticky snapshot of
//            presses. Option: BUTTON_CONDITIONER_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import breakout_input_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 400000
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 16000000,
  parameter int REPEAT_PERIOD = 4000000
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_BUTTONS-1:0] BTN_RAW,
  input  logic                 FRAME_TICK,
  output logic [N_BUTTONS-1:0] BTN_LEVEL,
  output logic [N_BUTTONS-1:0] BTN_PRESS,
  output logic [N_BUTTONS-1:0] FRAME_PRESSES
);

  logic [N_BUTTONS-1:0] w_level;
  logic [N_BUTTONS-1:0] w_press;
  logic [N_BUTTONS-1:0] acc_q, acc_d;
  logic [N_BUTTONS-1:0] frame_q, frame_d;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_db (
      .clk_i  (CLK),
      .rst_i  (RST),
      .raw_i  (BTN_RAW[g]),
      .level_o(w_level[g]),
      .press_o(w_press[g])
    );
  end

  // A press landing in the tick cycle is folded into the frame being closed.
  always_comb begin
    acc_d   = acc_q | w_press;
    frame_d = frame_q;
    if (FRAME_TICK) begin
      frame_d = acc_q | w_press;
      acc_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q   <= '0;
      frame_q <= '0;
    end else begin
      acc_q   <= acc_d;
      frame_q <= frame_d;
    end
  end

  assign BTN_LEVEL     = w_level;
  assign BTN_PRESS     = w_press;
  assign FRAME_PRESSES = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed bench for button_conditioner (DEBOUNCE_CYCLES=8,
//            REPEAT_DELAY=20, REPEAT_PERIOD=5 when auto-repeat is built in).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_conditioner;
  import breakout_input_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'h0;
  logic       tick = 1'b0;
  logic [3:0] level, press, frame;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS      (4),
    .DEBOUNCE_CYCLES(8)
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
`endif
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .BTN_RAW      (raw),
    .FRAME_TICK   (tick),
    .BTN_LEVEL    (level),
    .BTN_PRESS    (press),
    .FRAME_PRESSES(frame)
  );

  typedef struct {
    logic       r;
    logic [3:0] raw;
    logic       tk;
    int         reps;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] frm;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; raw = 4'h0; tick = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Holds B from edge 0 until edge rel, over edges 0..last; returns pulse edges as a mask.
  task automatic repeat_seq(input int rel, input int last, output logic [63:0] mask, output int fall);
    mask = '0;
    fall = -1;
    for (int e = 0; e <= last; e++) begin
      raw = (e < rel) ? 4'h8 : 4'h0;
      step();
      if (press[BTN_IDX_B]) mask[e] = 1'b1;
      if (e > 10 && !level[BTN_IDX_B] && fall < 0) fall = e;
    end
  endtask

  initial begin
    logic [63:0] mask, exp_mask;
    int pc, pe, rise, fall, npress;

    // reset, all-press, release, ticks, A press, B coincident with tick, glitch
    tbl[0]  = '{1'b1, 4'hF, 1'b0,  3, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 1'b0, 10, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b0,  1, 4'hF, 4'hF, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 1'b0,  3, 4'hF, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 10, 4'hF, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0,  1, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 4'h0, 1'b1,  1, 4'h0, 4'h0, 4'hF};
    tbl[7]  = '{1'b0, 4'h0, 1'b1,  1, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{1'b0, 4'h0, 1'b0,  2, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 4'h4, 1'b0, 10, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{1'b0, 4'h4, 1'b0,  1, 4'h4, 4'h4, 4'h0};
    tbl[11] = '{1'b0, 4'h4, 1'b0,  2, 4'h4, 4'h0, 4'h0};
    tbl[12] = '{1'b0, 4'h4, 1'b1,  1, 4'h4, 4'h0, 4'h4};
    tbl[13] = '{1'b0, 4'h4, 1'b0,  2, 4'h4, 4'h0, 4'h4};
    tbl[14] = '{1'b0, 4'h4, 1'b1,  1, 4'h4, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 4'hC, 1'b0, 10, 4'h4, 4'h0, 4'h0};
    tbl[16] = '{1'b0, 4'hC, 1'b0,  1, 4'hC, 4'h8, 4'h0};
    tbl[17] = '{1'b0, 4'hC, 1'b1,  1, 4'hC, 4'h0, 4'h8};
    tbl[18] = '{1'b0, 4'hC, 1'b0,  2, 4'hC, 4'h0, 4'h8};
    tbl[19] = '{1'b0, 4'hC, 1'b1,  1, 4'hC, 4'h0, 4'h0};
    tbl[20] = '{1'b0, 4'hE, 1'b0,  5, 4'hC, 4'h0, 4'h0};
    tbl[21] = '{1'b0, 4'hC, 1'b0, 12, 4'hC, 4'h0, 4'h0};

    for (int i = 0; i < 22; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        rst = tbl[i].r; raw = tbl[i].raw; tick = tbl[i].tk;
        step();
        check($sformatf("vec%0d.%0d level", i, r), 64'(level), 64'(tbl[i].lvl));
        check($sformatf("vec%0d.%0d press", i, r), 64'(press), 64'(tbl[i].prs));
        check($sformatf("vec%0d.%0d frame", i, r), 64'(frame), 64'(tbl[i].frm));
      end
    end
    tick = 1'b0;

    // RIGHT bounces 1,0,1,0 every 3 cycles, then holds from edge 12
    reset_dut();
    pc = 0; pe = -1;
    for (int e = 0; e < 32; e++) begin
      raw = 4'h0;
      raw[BTN_IDX_RIGHT] = (e < 3) || (e >= 6 && e < 9) || (e >= 12);
      step();
      if (press[BTN_IDX_RIGHT]) begin pc++; pe = e; end
    end
    check("bounce pulse count", 64'(pc), 64'd1);
    check("bounce pulse edge", 64'(pe), 64'd22);

    // LEFT: reset hits at cnt=5, latency restarts, then a clean release
    reset_dut();
    npress = 0; pe = -1; rise = -1; fall = -1;
    for (int e = 0; e <= 40; e++) begin
      raw = 4'h0;
      raw[BTN_IDX_LEFT] = (e < 22);
      rst = (e == 8);
      step();
      if (e == 8) check("midreset outputs", 64'({level, press, frame}), 64'd0);
      if (press[BTN_IDX_LEFT]) begin npress++; pe = e; end
      if (level[BTN_IDX_LEFT] && rise < 0) rise = e;
      if (rise >= 0 && !level[BTN_IDX_LEFT] && fall < 0) fall = e;
    end
    rst = 1'b0;
    check("midreset pulse count", 64'(npress), 64'd1);
    check("midreset pulse edge", 64'(pe), 64'd19);
    check("midreset level rise", 64'(rise), 64'd19);
    check("release level fall", 64'(fall), 64'd32);

    // B held long, then B released at edge 37
    reset_dut();
    repeat_seq(100, 44, mask, fall);
    exp_mask = '0;
    exp_mask[10] = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    exp_mask[30] = 1'b1; exp_mask[35] = 1'b1; exp_mask[40] = 1'b1;
`endif
    check("hold B pulse edges", mask, exp_mask);

    reset_dut();
    repeat_seq(37, 60, mask, fall);
    exp_mask = '0;
    exp_mask[10] = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    exp_mask[30] = 1'b1; exp_mask[35] = 1'b1;
`endif
    check("release B pulse edges", mask, exp_mask);
    check("release B level fall", 64'(fall), 64'd47);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
